sync_fifo_ctrl: RTL and testbench

//  Single-clock FIFO controller in front of the dual-port RAM block (registered read, 1-cycle latency).

---
 rtl/sync_fifo_ctrl.sv | 80 ++++++++
 tb/tb_sync_fifo_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO controller driving a registered-read dual-port RAM
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int AF_LEVEL   = 500,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] count_q;
    logic                push_ok;
    logic                pop_ok;

    // Flags decode only from registered occupancy, so accept decisions never depend on same-cycle requests.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign ram_wr_en   = push_ok;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = push_data;
    assign ram_rd_en   = pop_ok;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign pop_data    = ram_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ONE_C;
            if (pop_ok)  rd_ptr <= rd_ptr + ONE_C;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + ONE_C;
                2'b01:   count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
            pop_valid <= pop_ok;
            overflow  <= push & full;
            underflow <= pop & empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - randomized self-checking bench for sync_fifo_ctrl against a queue model
module tb_sync_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int AF    = 500;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] mem [DEPTH];
    int wr_total = 0;
    int rd_total = 0;

    always #5 clk = ~clk;

    // Registered-read RAM block the controller sits in front of.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_status();
        int n;
        n = mq.size();
        check("count", 32'(count), 32'(n));
        check("full", 32'(full), 32'(n == DEPTH));
        check("empty", 32'(empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    endtask

    // One clock cycle with the given requests; every observable output is checked against the model.
    task automatic step(input bit p, input bit q, input logic [DW-1:0] d);
        bit acc_push, acc_pop;
        logic [DW-1:0] exp_word;
        @(negedge clk);
        push = p; pop = q; push_data = d;
        #1;
        acc_push = p && (mq.size() < DEPTH);
        acc_pop  = q && (mq.size() > 0);
        exp_word = '0;
        check("ram_wr_en", 32'(ram_wr_en), 32'(acc_push));
        check("ram_rd_en", 32'(ram_rd_en), 32'(acc_pop));
        if (acc_push) begin
            check("ram_wr_addr", 32'(ram_wr_addr), 32'(wr_total % DEPTH));
            check("ram_wr_data", 32'(ram_wr_data), 32'(d));
        end
        if (acc_pop) check("ram_rd_addr", 32'(ram_rd_addr), 32'(rd_total % DEPTH));
        @(posedge clk);
        #1;
        if (acc_pop) begin
            exp_word = mq.pop_front();
            rd_total++;
        end
        if (acc_push) begin
            mq.push_back(d);
            wr_total++;
        end
        check("pop_valid", 32'(pop_valid), 32'(acc_pop));
        if (acc_pop) check("pop_data", 32'(pop_data), 32'(exp_word));
        check("overflow", 32'(overflow), 32'(p && !acc_push));
        check("underflow", 32'(underflow), 32'(q && !acc_pop));
        check_status();
    endtask

    task automatic model_reset();
        mq.delete();
        wr_total = 0;
        rd_total = 0;
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check_status();
        @(negedge clk);
        rst_n = 1'b1;

        // Three words in, three out back to back.
        step(1, 0, 8'hA1);
        step(1, 0, 8'hA2);
        step(1, 0, 8'hA3);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00);
        step(0, 0, 8'h00);
        check("t1_empty", 32'(empty), 32'd1);

        // Fill to full, then one rejected push.
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 8'(i));
            if (i == AF - 2) check("t2_af_before", 32'(almost_full), 32'd0);
            if (i == AF - 1) check("t2_af_at_500", 32'(almost_full), 32'd1);
        end
        check("t2_full", 32'(full), 32'd1);
        step(1, 0, 8'hEE);
        check("t2_ovf_pulse", 32'(overflow), 32'd1);
        check("t2_count", 32'(count), 32'(DEPTH));
        step(0, 0, 8'h00);
        check("t2_ovf_one_cycle", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop: settles at DEPTH-1 and streams through the wrap.
        for (int i = 0; i < 1000; i++) step(1, 1, 8'(i + 7));
        check("t3_count", 32'(count), 32'(DEPTH - 1));
        while (mq.size() > 0) step(0, 1, 8'h00);

        // Underflow on empty, then push and pop together on empty.
        step(0, 1, 8'h00);
        check("t4_unf", 32'(underflow), 32'd1);
        step(1, 1, 8'h5C);
        check("t4_unf_both", 32'(underflow), 32'd1);
        check("t4_count", 32'(count), 32'd1);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        // Reset landing in the pop_valid cycle.
        for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h30 + i));
        step(0, 1, 8'h00);
        rst_n = 1'b0;
        pop = 1'b0;
        #1;
        model_reset();
        check("t5_pop_valid_drop", 32'(pop_valid), 32'd0);
        check("t5_count", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 8'h9D);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        // Random traffic.
        for (int i = 0; i < 20000; i++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
